// File: rtl/seed_overcurrent_interlock.sv
// Seed-laser over-current interlock.
//
// This block watches two over-current sources:
//   - ADC current samples, checked against a mode-selected limit with a sample debounce.
//   - The analog comparator pin, passed through a synchronizer and a glitch filter.
// Either source latches a trip. The trip stays latched until a clear request arrives.
// After a clear, a holdoff period runs before the interlock re-arms. A comparator hit
// during the holdoff trips the interlock again.
//
// Ports
//   clk, rst                   clock; asynchronous active-high reset
//   laser_active               interlock is armed only while high
//   dds_cw_mode_select         0 = DDS limit in force, 1 = CW limit in force
//   dds_current_limit          DDS-mode limit, loaded on dds_current_limit_update
//   dds_current_limit_update   1-cycle load strobe for dds_current_limit
//   cw_current_limit           CW-mode limit, loaded on cw_current_limit_update
//   cw_current_limit_update    1-cycle load strobe for cw_current_limit
//   adc_data_valid             1-cycle strobe; adc_current_data is valid
//   adc_current_data           unsigned current sample
//   seed_compared              asynchronous comparator input, high = over current
//   trip_clear                 1-cycle clear request; acted on only while tripped
//   over_current_limit         latched trip flag
//   trip_cause                 bit0 = ADC limit, bit1 = comparator
//   trip_count                 saturating count of trips since reset
//   peak_current               largest sample seen while armed
//   state_dbg                  FSM state: 0 idle, 1 armed, 2 tripped, 3 holdoff
`timescale 1ns/1ps

module seed_overcurrent_interlock #(
   parameter int unsigned SAMPLE_COUNT = 3,
   parameter int unsigned CMP_FILT     = 4,
   parameter int unsigned HOLDOFF      = 10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        laser_active,
   input  logic        dds_cw_mode_select,
   input  logic [15:0] dds_current_limit,
   input  logic [15:0] cw_current_limit,
   input  logic        dds_current_limit_update,
   input  logic        cw_current_limit_update,
   input  logic        adc_data_valid,
   input  logic [15:0] adc_current_data,
   input  logic        seed_compared,
   input  logic        trip_clear,
   output logic        over_current_limit,
   output logic [1:0]  trip_cause,
   output logic [7:0]  trip_count,
   output logic [15:0] peak_current,
   output logic [1:0]  state_dbg
);

   localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HoldW-1:0] HoldLast     = HoldW'(HOLDOFF - 1);
   localparam logic [3:0]       SampleTarget = 4'(SAMPLE_COUNT);
   localparam logic [7:0]       FiltTarget   = 8'(CMP_FILT);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StArmed    = 2'd1,
      StTripped  = 2'd2,
      StHoldoff  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [15:0]       dds_limit_q, cw_limit_q;
   logic              cmp_meta_q, cmp_sync_q;
   logic [7:0]        filt_q, filt_d;
   logic [3:0]        over_q, over_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic              ocl_q, ocl_d;
   logic [1:0]        cause_q, cause_d;
   logic [7:0]        count_q, count_d;
   logic [15:0]       peak_q, peak_d;

   logic [15:0]       active_limit;
   logic              sample_over;
   logic              adc_hit;
   logic              cmp_hit;
   logic              enter_trip;
   logic              enter_hold;

   // Limit registers start at full scale, so the ADC path cannot trip until a limit is loaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dds_limit_q <= 16'hFFFF;
         cw_limit_q  <= 16'hFFFF;
      end else begin
         if (dds_current_limit_update) dds_limit_q <= dds_current_limit;
         if (cw_current_limit_update)  cw_limit_q  <= cw_current_limit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_meta_q <= 1'b0;
         cmp_sync_q <= 1'b0;
      end else begin
         cmp_meta_q <= seed_compared;
         cmp_sync_q <= cmp_meta_q;
      end
   end

   // Sample datapath and glitch filter.
   always_comb begin
      active_limit = dds_cw_mode_select ? cw_limit_q : dds_limit_q;
      sample_over  = adc_current_data > active_limit;
      cmp_hit      = (filt_q == FiltTarget);

      filt_d = filt_q;
      if (state_q == StIdle || !cmp_sync_q) begin
         filt_d = 8'd0;
      end else if (filt_q != FiltTarget) begin
         filt_d = filt_q + 8'd1;
      end

      // The over-count only runs while armed. Testing the next value lets the trip
      // land on the clock edge that closes the qualifying sample.
      over_d = over_q;
      if (state_q != StArmed) begin
         over_d = 4'd0;
      end else if (adc_data_valid) begin
         over_d = sample_over ? over_q + 4'd1 : 4'd0;
      end
      adc_hit = (state_q == StArmed) && adc_data_valid && (over_d == SampleTarget);
   end

   // Next-state logic and sticky bookkeeping.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      enter_trip = 1'b0;
      enter_hold = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (laser_active) state_d = StArmed;
         end
         StArmed: begin
            // A trip takes priority over disarming in the same cycle.
            if (adc_hit || cmp_hit) begin
               state_d    = StTripped;
               enter_trip = 1'b1;
            end else if (!laser_active) begin
               state_d = StIdle;
            end
         end
         StTripped: begin
            if (trip_clear) begin
               state_d    = StHoldoff;
               enter_hold = 1'b1;
               hold_d     = '0;
            end
         end
         StHoldoff: begin
            if (cmp_hit) begin
               state_d    = StTripped;
               enter_trip = 1'b1;
            end else if (hold_q == HoldLast) begin
               state_d = laser_active ? StArmed : StIdle;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      cause_d = cause_q;
      if (enter_hold) begin
         cause_d = 2'b00;
      end else if (enter_trip) begin
         cause_d = cause_q | {cmp_hit, adc_hit};
      end

      count_d = count_q;
      if (enter_trip && count_q != 8'hFF) count_d = count_q + 8'd1;

      peak_d = peak_q;
      if (enter_hold) begin
         peak_d = 16'd0;
      end else if (state_q == StArmed && adc_data_valid && adc_current_data > peak_q) begin
         peak_d = adc_current_data;
      end

      ocl_d = (state_d == StTripped);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         filt_q  <= 8'd0;
         over_q  <= 4'd0;
         hold_q  <= '0;
         ocl_q   <= 1'b0;
         cause_q <= 2'b00;
         count_q <= 8'd0;
         peak_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         filt_q  <= filt_d;
         over_q  <= over_d;
         hold_q  <= hold_d;
         ocl_q   <= ocl_d;
         cause_q <= cause_d;
         count_q <= count_d;
         peak_q  <= peak_d;
      end
   end

   assign over_current_limit = ocl_q;
   assign trip_cause         = cause_q;
   assign trip_count         = count_q;
   assign peak_current       = peak_q;
   assign state_dbg          = state_q;

endmodule
